// File: rtl/add_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : add_result_checker
// Description : Launch-to-completion checker for an asynchronous adder.
//               Synchronizes the adder completion flag, measures latency,
//               captures the bundled sum one cycle after completion, compares
//               it against a golden reference and keeps pass/fail tallies.
// Revision    : 1.0 - initial release
// ============================================================================
module add_result_checker #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fin_async,
    input  logic [WIDTH-1:0] s_async,
    input  logic             cout_async,
    input  logic [WIDTH-1:0] s_ref,
    input  logic             cout_ref,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [15:0]      latency,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt
);

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_fin_meta;
    logic        r_fin_sync;
    logic        r_fin_base;
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_lat_det;
    logic        r_pass;
    logic        r_timeout;
    logic [15:0] r_latency;
    logic [15:0] r_pass_cnt;
    logic [15:0] r_fail_cnt;

    logic        w_complete;
    logic        w_tmo_hit;
    logic        w_match;

    // A level difference from the launch-time baseline covers both a 2-phase
    // toggle and a 4-phase rising edge.
    assign w_complete = (r_fin_sync != r_fin_base);
    assign w_tmo_hit  = (r_state == S_WAIT) && !w_complete && (r_cycle_cnt == c_timeout);
    // Full carry+sum compare against the golden result.
    assign w_match    = ({cout_async, s_async} == {cout_ref, s_ref});

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_REPORT);
    assign pass     = r_pass;
    assign timeout  = r_timeout;
    assign latency  = r_latency;
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;

    // Two-flop synchronizer: the only logic that touches fin_async.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fin_meta <= 1'b0;
            r_fin_sync <= 1'b0;
        end else begin
            r_fin_meta <= fin_async;
            r_fin_sync <= r_fin_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_complete) begin
                    w_state_nxt = S_CAPTURE;
                end else if (r_cycle_cnt == c_timeout) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_CAPTURE: w_state_nxt = S_REPORT;
            S_REPORT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Launch baseline, cycle counter and latency at completion detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fin_base  <= 1'b0;
            r_cycle_cnt <= 16'd0;
            r_lat_det   <= 16'd0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_fin_base  <= r_fin_sync;
                r_cycle_cnt <= 16'd0;
            end else if (r_state == S_WAIT) begin
                if (w_complete) begin
                    r_lat_det <= r_cycle_cnt;
                end else if (r_cycle_cnt != c_timeout) begin
                    r_cycle_cnt <= r_cycle_cnt + 16'd1;
                end
            end
        end
    end

    // Result registers, loaded on entry to REPORT so they are valid with done.
    // The sum is sampled exactly once, at the edge leaving CAPTURE; only the
    // compare outcome needs to be kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_latency  <= 16'd0;
            r_pass_cnt <= 16'd0;
            r_fail_cnt <= 16'd0;
        end else if (r_state == S_CAPTURE) begin
            r_pass    <= w_match;
            r_timeout <= 1'b0;
            r_latency <= r_lat_det;
            if (w_match) begin
                if (r_pass_cnt != c_cnt_max) begin
                    r_pass_cnt <= r_pass_cnt + 16'd1;
                end
            end else begin
                if (r_fail_cnt != c_cnt_max) begin
                    r_fail_cnt <= r_fail_cnt + 16'd1;
                end
            end
        end else if (w_tmo_hit) begin
            r_pass    <= 1'b0;
            r_timeout <= 1'b1;
            r_latency <= c_timeout;
            if (r_fail_cnt != c_cnt_max) begin
                r_fail_cnt <= r_fail_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_result_checker
// Description : Self-checking bench for add_result_checker. Expected reports
//               are queued at launch and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_result_checker;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             fin_async;
    logic [WIDTH-1:0] s_async;
    logic             cout_async;
    logic [WIDTH-1:0] s_ref;
    logic             cout_ref;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [15:0]      latency;
    logic [15:0]      pass_cnt;
    logic [15:0]      fail_cnt;

    typedef struct packed {
        logic        pass;
        logic        tmo;
        logic [15:0] lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_pass_cnt;
    logic [15:0] exp_fail_cnt;
    logic [51:0] obs;
    logic [51:0] req;
    bit          got;

    add_result_checker #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .fin_async(fin_async),
        .s_async(s_async), .cout_async(cout_async),
        .s_ref(s_ref), .cout_ref(cout_ref),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .latency(latency), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and queue the expected report.
    task automatic launch(input logic p, input logic t, input logic [15:0] l);
        exp_t x;
        x.pass = p;
        x.tmo  = t;
        x.lat  = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(x);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Reference counters, saturating at 16'hFFFF.
    task automatic model_update(input exp_t x);
        if (x.pass && !x.tmo) begin
            if (exp_pass_cnt != 16'hFFFF) exp_pass_cnt = exp_pass_cnt + 16'd1;
        end else begin
            if (exp_fail_cnt != 16'hFFFF) exp_fail_cnt = exp_fail_cnt + 16'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; fin_async = 1'b0;
        s_async = '0; cout_async = 1'b0; s_ref = '0; cout_ref = 1'b0;
        exp_pass_cnt = 16'd0; exp_fail_cnt = 16'd0;
        repeat (3) tick();
        obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
        vectors++;
        if (obs !== 52'd0) begin
            errors++;
            $display("FAIL reset_with_start: got %h want %h", obs, 52'd0);
        end
        rst = 1'b0; start = 1'b0;
        repeat (3) tick();
        obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
        vectors++;
        if (obs !== 52'd0) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", obs, 52'd0);
        end
    endtask

    task automatic test_basic();
        s_ref = 32'h0000_0000; cout_ref = 1'b1;
        s_async = 32'h0000_0000; cout_async = 1'b1;
        launch(1'b1, 1'b0, 16'd7);
        repeat (5) tick();
        fin_async = 1'b1;
        wait_done(got);
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL basic_report: got no done want done");
        end else begin
            e = sb.pop_front();
            model_update(e);
            obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
            req = {2'b11, e.pass, e.tmo, e.lat, exp_pass_cnt, exp_fail_cnt};
            if (obs !== req) begin
                errors++;
                $display("FAIL basic_report: got %h want %h", obs, req);
            end
        end
        tick();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL basic_done_one_cycle: got busy,done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_two_phase();
        s_ref = 32'hDEAD_BEEF; cout_ref = 1'b0;
        s_async = 32'hDEAD_BEEF; cout_async = 1'b0;
        repeat (2) tick();
        launch(1'b1, 1'b0, 16'd3);
        tick();
        fin_async = 1'b0;
        wait_done(got);
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL two_phase_report: got no done want done");
        end else begin
            e = sb.pop_front();
            model_update(e);
            obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
            req = {2'b11, e.pass, e.tmo, e.lat, exp_pass_cnt, exp_fail_cnt};
            if (obs !== req) begin
                errors++;
                $display("FAIL two_phase_report: got %h want %h", obs, req);
            end
        end
        s_async = 32'h0BAD_F00D;
        tick();
        vectors++;
        if ({done, pass, pass_cnt} !== {2'b01, exp_pass_cnt}) begin
            errors++;
            $display("FAIL two_phase_hold: got done,pass,cnt=%h want %h",
                     {done, pass, pass_cnt}, {2'b01, exp_pass_cnt});
        end
    endtask

    task automatic test_mismatch();
        s_ref = 32'h1234_5679; cout_ref = 1'b0;
        s_async = 32'h1234_5678; cout_async = 1'b0;
        repeat (2) tick();
        launch(1'b0, 1'b0, 16'd5);
        repeat (3) tick();
        fin_async = 1'b1;
        wait_done(got);
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL mismatch_report: got no done want done");
        end else begin
            e = sb.pop_front();
            model_update(e);
            obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
            req = {2'b11, e.pass, e.tmo, e.lat, exp_pass_cnt, exp_fail_cnt};
            if (obs !== req) begin
                errors++;
                $display("FAIL mismatch_report: got %h want %h", obs, req);
            end
        end
    endtask

    // fin_async never moves; a stray start mid-WAIT must not restart the count.
    task automatic test_timeout();
        repeat (2) tick();
        launch(1'b0, 1'b1, 16'(TIMEOUT));
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy: got %b want 1", busy);
        end
        repeat (TIMEOUT - 3) tick();
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got done=%b want 0", done);
        end
        tick();
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_report: got done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            model_update(e);
            obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
            req = {2'b11, e.pass, e.tmo, e.lat, exp_pass_cnt, exp_fail_cnt};
            if (obs !== req) begin
                errors++;
                $display("FAIL timeout_report: got %h want %h", obs, req);
            end
        end
    endtask

    task automatic test_back_to_back();
        s_ref = 32'hAAAA_5555; cout_ref = 1'b1;
        s_async = 32'hAAAA_5555; cout_async = 1'b1;
        repeat (2) tick();
        launch(1'b1, 1'b0, 16'd4);
        repeat (2) tick();
        fin_async = 1'b0;
        wait_done(got);
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_first: got no done want done");
        end else begin
            e = sb.pop_front();
            model_update(e);
            obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
            req = {2'b11, e.pass, e.tmo, e.lat, exp_pass_cnt, exp_fail_cnt};
            if (obs !== req) begin
                errors++;
                $display("FAIL b2b_first: got %h want %h", obs, req);
            end
        end
        // start during the REPORT cycle is dropped.
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_in_report: got busy=%b want 0", busy);
        end
        // Carry-out alone differs.
        cout_async = 1'b0;
        launch(1'b0, 1'b0, 16'd3);
        tick();
        fin_async = 1'b1;
        wait_done(got);
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_second: got no done want done");
        end else begin
            e = sb.pop_front();
            model_update(e);
            obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
            req = {2'b11, e.pass, e.tmo, e.lat, exp_pass_cnt, exp_fail_cnt};
            if (obs !== req) begin
                errors++;
                $display("FAIL b2b_second: got %h want %h", obs, req);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (done) seen = 1'b1;
        rst = 1'b1;
        tick();
        if (done) seen = 1'b1;
        exp_pass_cnt = 16'd0;
        exp_fail_cnt = 16'd0;
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_no_done: got done pulse want none");
        end
        obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
        vectors++;
        if (obs !== 52'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h want %h", obs, 52'd0);
        end
        rst = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_idle: got busy,done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_saturation();
        s_ref = 32'h0F0F_F0F0; cout_ref = 1'b0;
        s_async = 32'h0F0F_F0F0; cout_async = 1'b0;
        repeat (3) tick();
        force dut.r_pass_cnt = 16'hFFFE;
        tick();
        release dut.r_pass_cnt;
        exp_pass_cnt = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            launch(1'b1, 1'b0, 16'd3);
            tick();
            fin_async = ~fin_async;
            wait_done(got);
            vectors++;
            if (!got) begin
                errors++;
                $display("FAIL saturate_%0d: got no done want done", n);
            end else begin
                e = sb.pop_front();
                model_update(e);
                obs = {busy, done, pass, timeout, latency, pass_cnt, fail_cnt};
                req = {2'b11, e.pass, e.tmo, e.lat, exp_pass_cnt, exp_fail_cnt};
                if (obs !== req) begin
                    errors++;
                    $display("FAIL saturate_%0d: got %h want %h", n, obs, req);
                end
            end
            repeat (3) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_phase();
        test_mismatch();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
